// File: rtl/add_operand_pair.sv
// Operand pairing stage for the add wrapper: two DEPTH-entry FIFOs (A, B)
// whose heads are popped together and issued as one registered beat.

module add_operand_pair_fifo #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  input  logic [BITS-1:0]            data_i,
  input  logic                       pop_i,
  output logic                       ready_o,
  output logic [BITS-1:0]            head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][BITS-1:0] mem_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              count_q, count_d;
  logic                       push;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign ready_o = !rst && (count_q < FULL);
  assign push    = push_valid_i && ready_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data_i;
  end
endmodule

module add_operand_pair #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [BITS-1:0]        a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [BITS-1:0]        b_data,
  input  logic                   hold,
  output logic                   out_valid,
  output logic [BITS-1:0]        out_a,
  output logic [BITS-1:0]        out_b,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Index 0 is the A stream, index 1 the B stream.
  logic [1:0]                 vld, rdy;
  logic [1:0][BITS-1:0]       din, head;
  logic [1:0][CW-1:0]         cnt;
  logic                       pop;
  logic                       out_valid_q;
  logic [BITS-1:0]            out_a_q, out_b_q;

  assign vld = {b_valid, a_valid};
  assign din = {b_data, a_data};

  // Both heads leave together, which keeps the k-th A paired with the k-th B.
  assign pop = !rst && !hold && (cnt[0] != '0) && (cnt[1] != '0);

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    add_operand_pair_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (vld[g]),
      .data_i       (din[g]),
      .pop_i        (pop),
      .ready_o      (rdy[g]),
      .head_o       (head[g]),
      .count_o      (cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      out_valid_q <= pop;
      if (pop) begin
        out_a_q <= head[0];
        out_b_q <= head[1];
      end
    end
  end

  assign a_ready   = rdy[0];
  assign b_ready   = rdy[1];
  assign a_count   = cnt[0];
  assign b_count   = cnt[1];
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
endmodule

// File: tb/tb_add_operand_pair.sv
// Bench for add_operand_pair: per-cycle queue model plus directed table and sequences.

module tb_add_operand_pair;
  localparam int BITS  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, a_valid, b_valid, hold;
  logic [BITS-1:0] a_data, b_data;
  logic            a_ready, b_ready, out_valid;
  logic [BITS-1:0] out_a, out_b;
  logic [CW-1:0]   a_count, b_count;

  add_operand_pair #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .hold(hold), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: two queues and the last issued pair.
  logic [BITS-1:0] qa[$], qb[$];
  logic            m_vld = 1'b0;
  logic [BITS-1:0] m_a = '0, m_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic pop, pa, pb;
    if (rst) begin
      qa.delete(); qb.delete();
      m_vld = 1'b0; m_a = '0; m_b = '0;
    end else begin
      pop = !hold && qa.size() > 0 && qb.size() > 0;
      pa  = a_valid && qa.size() < DEPTH;
      pb  = b_valid && qb.size() < DEPTH;
      m_vld = pop;
      if (pop) begin
        m_a = qa.pop_front();
        m_b = qb.pop_front();
      end
      if (pa) qa.push_back(a_data);
      if (pb) qb.push_back(b_data);
    end
  endtask

  task automatic model_check();
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_a",     32'(out_a),     32'(m_a));
    chk("out_b",     32'(out_b),     32'(m_b));
    chk("a_count",   32'(a_count),   32'(qa.size()));
    chk("b_count",   32'(b_count),   32'(qb.size()));
    chk("a_ready",   32'(a_ready),   32'(!rst && qa.size() < DEPTH));
    chk("b_ready",   32'(b_ready),   32'(!rst && qb.size() < DEPTH));
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input logic av, input logic [BITS-1:0] ad,
                       input logic bv, input logic [BITS-1:0] bd, input logic h);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; hold = h;
  endtask

  typedef struct {
    logic            av;
    logic [BITS-1:0] ad;
    logic            bv;
    logic [BITS-1:0] bd;
    logic            vld;
    logic [BITS-1:0] oa, ob;
    int              ac, bc;
  } vec_t;

  function automatic vec_t mk(logic av, logic [BITS-1:0] ad, logic bv, logic [BITS-1:0] bd,
                              logic vld, logic [BITS-1:0] oa, logic [BITS-1:0] ob, int ac, int bc);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    v.vld = vld; v.oa = oa; v.ob = ob; v.ac = ac; v.bc = bc;
    return v;
  endfunction

  vec_t tv[16];

  initial begin
    int nv, k, maxc;
    logic [15:0] h0, h1;
    h0 = 16'h3C00; h1 = 16'h4000;
    // Basic pair, then skewed A/B streams; expected values after each edge.
    tv[0]  = mk(1, h0, 1, h1, 0, 0, 0, 1, 1);
    tv[1]  = mk(0, 0, 0, 0,   1, h0, h1, 0, 0);
    tv[2]  = mk(0, 0, 0, 0,   0, h0, h1, 0, 0);
    tv[3]  = mk(1, 1, 0, 0,   0, h0, h1, 1, 0);
    tv[4]  = mk(1, 2, 0, 0,   0, h0, h1, 2, 0);
    tv[5]  = mk(1, 3, 0, 0,   0, h0, h1, 3, 0);
    for (int i = 6; i < 11; i++) tv[i] = mk(0, 0, 0, 0, 0, h0, h1, 3, 0);
    tv[11] = mk(0, 0, 1, 10,  0, h0, h1, 3, 1);
    tv[12] = mk(0, 0, 1, 20,  1, 1, 10, 2, 1);
    tv[13] = mk(0, 0, 1, 30,  1, 2, 20, 1, 1);
    tv[14] = mk(0, 0, 0, 0,   1, 3, 30, 0, 0);
    tv[15] = mk(0, 0, 0, 0,   0, 3, 30, 0, 0);

    // Reset held 3 cycles with both producers valid.
    rst = 1'b1; drive(1, 16'h5555, 1, 16'hAAAA, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_count",   32'({a_count, b_count}), 0);
    end
    rst = 1'b0; drive(0, 0, 0, 0, 0);
    #1;
    chk("rel_ready", 32'({a_ready, b_ready}), 32'h3);

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].av, tv[i].ad, tv[i].bv, tv[i].bd, 0);
      tick();
      chk($sformatf("tv%0d_vld", i), 32'(out_valid), 32'(tv[i].vld));
      chk($sformatf("tv%0d_a", i),   32'(out_a),     32'(tv[i].oa));
      chk($sformatf("tv%0d_b", i),   32'(out_b),     32'(tv[i].ob));
      chk($sformatf("tv%0d_ac", i),  32'(a_count),   32'(tv[i].ac));
      chk($sformatf("tv%0d_bc", i),  32'(b_count),   32'(tv[i].bc));
    end

    // Full: six A offers, only four fit.
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'hA1 + 16'(i), 0, 0, 0);
      tick();
    end
    chk("full_count", 32'(a_count), 4);
    chk("full_ready", 32'(a_ready), 0);
    drive(0, 0, 1, 16'hB1, 0);
    tick();
    chk("full_ready_b1", 32'(a_ready), 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("full_pop_vld", 32'(out_valid), 1);
    chk("full_pop_pair", 32'({out_a, out_b}), {16'hA1, 16'hB1});
    chk("full_ready_back", 32'(a_ready), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'hB2 + 16'(i), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("full_drained", 32'({a_count, b_count}), 0);

    // Hold for 4 cycles while two pairs are loaded.
    nv = 0;
    drive(1, 16'h11, 1, 16'h21, 1); tick(); nv += int'(out_valid);
    drive(1, 16'h12, 1, 16'h22, 1); tick(); nv += int'(out_valid);
    drive(0, 0, 0, 0, 1);           tick(); nv += int'(out_valid);
    tick(); nv += int'(out_valid);
    chk("hold_no_issue", 32'(nv), 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("hold_pair1", 32'({out_valid, out_a, out_b}), {1'b1, 16'h11, 16'h21} );
    tick();
    chk("hold_pair2", 32'({out_valid, out_a, out_b}), {1'b1, 16'h12, 16'h22} );
    tick();
    chk("hold_done", 32'(out_valid), 0);

    // Streaming across pointer wraps.
    k = 0; maxc = 0;
    for (int i = 0; i < 23; i++) begin
      if (i < 20) drive(1, 16'(i), 1, 16'(100 + i), 0);
      else        drive(0, 0, 0, 0, 0);
      tick();
      if (int'(a_count) > maxc) maxc = int'(a_count);
      if (int'(b_count) > maxc) maxc = int'(b_count);
      if (out_valid) begin
        chk("stream_pair", 32'({out_a, out_b}), {16'(k), 16'(100 + k)});
        k++;
      end
    end
    chk("stream_beats", 32'(k), 20);
    chk("stream_maxcnt", 32'(maxc), 1);

    // Reset mid-operation discards buffered operands and a pending beat.
    drive(1, 16'h77, 1, 16'h88, 0); tick();
    drive(1, 16'h78, 0, 0, 0);      tick();
    rst = 1'b1; drive(0, 0, 0, 0, 0); tick();
    chk("midrst_vld", 32'(out_valid), 0);
    rst = 1'b0; tick(); tick();
    chk("midrst_empty", 32'({out_valid, a_count, b_count}), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 80) == 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
            16'($urandom), $urandom_range(0, 4) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
